// File: rtl/adxl_reg_pkg.sv
// Shared constants and FSM state encoding for the register-bank access arbiter.
package adxl_reg_pkg;

    localparam int unsigned ADDR_W       = 7;
    localparam int unsigned SAMPLE_W     = 72;
    localparam int unsigned SAMPLE_BYTES = SAMPLE_W / 8;

    localparam logic [ADDR_W-1:0] DATA_BASE = 7'h08;
    localparam logic [ADDR_W-1:0] FIFO_ADDR = 7'h11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPI_RD,
        ST_RD_WAIT,
        ST_SPI_WR,
        ST_UPD
    } arb_state_e;

endpackage

// File: rtl/sample_shadow_buf.sv
// Holds the newest XYZ sample until the arbiter copies it into the bank, and
// flags samples that are overwritten before they were ever written.
module sample_shadow_buf
    import adxl_reg_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                sample_valid_i,
    input  logic [SAMPLE_W-1:0] sample_data_i,
    input  logic                upd_start_i,
    input  logic [3:0]          byte_sel_i,
    output logic                pending_o,
    output logic                sample_drop_o,
    output logic [7:0]          byte_o
);

    logic [SAMPLE_W-1:0] buf_q, buf_d;
    logic [SAMPLE_W-1:0] act_q, act_d;
    logic                pend_q, pend_d;
    logic                drop_q, drop_d;

    // The update streams from a private copy taken at start, so pending can
    // drop at start instead of at the end: a sample arriving mid-update then
    // simply becomes the next pending one and is never counted as dropped.
    always_comb begin
        buf_d  = sample_valid_i ? sample_data_i : buf_q;
        act_d  = upd_start_i ? buf_q : act_q;
        pend_d = sample_valid_i | (pend_q & ~upd_start_i);
        drop_d = sample_valid_i & pend_q & ~upd_start_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_q  <= '0;
            act_q  <= '0;
            pend_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    always_comb begin
        byte_o = '0;
        for (int unsigned k = 0; k < SAMPLE_BYTES; k++) begin
            if (byte_sel_i == 4'(k)) begin
                byte_o = act_q[SAMPLE_W-1-8*k -: 8];
            end
        end
    end

    assign pending_o     = pend_q;
    assign sample_drop_o = drop_q;

endmodule

// File: rtl/reg_access_arbiter.sv
// Arbitrates the single-port 128x8 register bank between SPI burst accesses
// (priority) and 9-byte sample updates deferred until chip select is released.
module reg_access_arbiter
    import adxl_reg_pkg::*;
(
    input  logic                mems_clk,
    input  logic                rst_n,
    input  logic                cs_n,
    input  logic [ADDR_W-1:0]   spi_wr_rd_addr,
    input  logic                spi_rd_addr_valid,
    input  logic [7:0]          spi_wr_data,
    input  logic                spi_wr_data_valid,
    output logic                reg_spi_rd_valid,
    output logic [7:0]          reg_spi_rd_data,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_drop,
    output logic                fifo_pop,
    output logic                bank_en,
    output logic                bank_we,
    output logic [ADDR_W-1:0]   bank_addr,
    output logic [7:0]          bank_wdata,
    input  logic [7:0]          bank_rdata
);

    arb_state_e        state_q, state_d;
    logic              rd_vld_q, wr_vld_q;
    logic              rd_queued_q, rd_queued_d;
    logic              wr_queued_q, wr_queued_d;
    logic              first_q, first_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] acc_q, acc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic [7:0]        rd_data_q, rd_data_d;

    logic              rd_edge, wr_edge, rd_pend, wr_pend;
    logic              rd_serve, wr_serve, upd_start;
    logic [ADDR_W-1:0] acc_addr;
    logic              pending;
    logic [7:0]        upd_byte;

    sample_shadow_buf u_shadow (
        .clk_i          (mems_clk),
        .rst_n_i        (rst_n),
        .sample_valid_i (sample_valid),
        .sample_data_i  (sample_data),
        .upd_start_i    (upd_start),
        .byte_sel_i     (cnt_q),
        .pending_o      (pending),
        .sample_drop_o  (sample_drop),
        .byte_o         (upd_byte)
    );

    always_comb begin
        rd_edge  = spi_rd_addr_valid & ~rd_vld_q;
        wr_edge  = spi_wr_data_valid & ~wr_vld_q;
        // Requests only live while the SPI frame is open; releasing cs_n drops them.
        rd_pend  = ~cs_n & (rd_edge | rd_queued_q);
        wr_pend  = ~cs_n & (wr_edge | wr_queued_q);
        acc_addr = first_q ? spi_wr_rd_addr : ptr_q;

        state_d    = state_q;
        rd_serve   = 1'b0;
        wr_serve   = 1'b0;
        upd_start  = 1'b0;
        ptr_d      = ptr_q;
        first_d    = first_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        bank_en    = 1'b0;
        bank_we    = 1'b0;
        bank_addr  = '0;
        bank_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                if (rd_pend) begin
                    rd_serve = 1'b1;
                    state_d  = ST_SPI_RD;
                end else if (wr_pend) begin
                    wr_serve = 1'b1;
                    state_d  = ST_SPI_WR;
                end else if (pending && cs_n) begin
                    upd_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_UPD;
                end
            end
            ST_SPI_RD: begin
                bank_en   = 1'b1;
                bank_addr = acc_q;
                state_d   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                rd_valid_d = 1'b1;
                rd_data_d  = bank_rdata;
                state_d    = ST_IDLE;
            end
            ST_SPI_WR: begin
                bank_en    = 1'b1;
                bank_we    = 1'b1;
                bank_addr  = acc_q;
                bank_wdata = spi_wr_data;
                state_d    = ST_IDLE;
            end
            ST_UPD: begin
                bank_en    = 1'b1;
                bank_we    = 1'b1;
                bank_addr  = DATA_BASE + {{(ADDR_W-4){1'b0}}, cnt_q};
                bank_wdata = upd_byte;
                if (cnt_q == 4'(SAMPLE_BYTES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_serve || wr_serve) begin
            acc_d   = acc_addr;
            ptr_d   = (acc_addr == FIFO_ADDR) ? acc_addr : acc_addr + 7'd1;
            first_d = 1'b0;
        end
        if (cs_n) begin
            first_d = 1'b1;
        end

        rd_queued_d = rd_pend & ~rd_serve;
        wr_queued_d = wr_pend & ~wr_serve;

        fifo_pop = bank_en & ~bank_we & (bank_addr == FIFO_ADDR);
    end

    always_ff @(posedge mems_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_vld_q    <= 1'b0;
            wr_vld_q    <= 1'b0;
            rd_queued_q <= 1'b0;
            wr_queued_q <= 1'b0;
            first_q     <= 1'b1;
            ptr_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_vld_q    <= spi_rd_addr_valid;
            wr_vld_q    <= spi_wr_data_valid;
            rd_queued_q <= rd_queued_d;
            wr_queued_q <= wr_queued_d;
            first_q     <= first_d;
            ptr_q       <= ptr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign reg_spi_rd_valid = rd_valid_q;
    assign reg_spi_rd_data  = rd_data_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: an ordered queue of expected bank
// accesses and read returns is built from the burst/update rules and checked every cycle.
module tb_reg_access_arbiter;

    logic        mems_clk;
    logic        rst_n;
    logic        cs_n;
    logic [6:0]  spi_wr_rd_addr;
    logic        spi_rd_addr_valid;
    logic [7:0]  spi_wr_data;
    logic        spi_wr_data_valid;
    logic        reg_spi_rd_valid;
    logic [7:0]  reg_spi_rd_data;
    logic        sample_valid;
    logic [71:0] sample_data;
    logic        sample_drop;
    logic        fifo_pop;
    logic        bank_en;
    logic        bank_we;
    logic [6:0]  bank_addr;
    logic [7:0]  bank_wdata;
    logic [7:0]  bank_rdata;

    reg_access_arbiter dut (
        .mems_clk          (mems_clk),
        .rst_n             (rst_n),
        .cs_n              (cs_n),
        .spi_wr_rd_addr    (spi_wr_rd_addr),
        .spi_rd_addr_valid (spi_rd_addr_valid),
        .spi_wr_data       (spi_wr_data),
        .spi_wr_data_valid (spi_wr_data_valid),
        .reg_spi_rd_valid  (reg_spi_rd_valid),
        .reg_spi_rd_data   (reg_spi_rd_data),
        .sample_valid      (sample_valid),
        .sample_data       (sample_data),
        .sample_drop       (sample_drop),
        .fifo_pop          (fifo_pop),
        .bank_en           (bank_en),
        .bank_we           (bank_we),
        .bank_addr         (bank_addr),
        .bank_wdata        (bank_wdata),
        .bank_rdata        (bank_rdata)
    );

    typedef struct {
        bit         we;
        logic [6:0] addr;
        logic [7:0] data;
        int         due;
    } acc_t;

    typedef struct {
        logic [7:0] data;
        int         due;
    } rd_t;

    acc_t       exp_q[$];
    rd_t        rdq[$];
    logic [7:0] rd_log[$];
    logic [7:0] env_mem[128];
    logic [7:0] model_mem[128];
    logic [7:0] prev_data;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         drop_cnt = 0;
    int         pop_cnt = 0;

    initial mems_clk = 1'b0;
    always #5 mems_clk = ~mems_clk;

    always @(posedge mems_clk) cyc <= cyc + 1;

    // Register bank: read data appears the cycle after the read strobe.
    always @(posedge mems_clk) begin
        if (bank_en) begin
            if (bank_we) env_mem[bank_addr] <= bank_wdata;
            else         bank_rdata <= env_mem[bank_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge mems_clk) begin
        if (rst_n) begin
            chk("fifo_pop_rule", fifo_pop, bank_en && !bank_we && bank_addr == 7'h11);
            if (bank_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bank_access", {bank_we, bank_addr}, 32'hFFFF);
                end else begin
                    acc_t e;
                    e = exp_q.pop_front();
                    chk("bank_we", bank_we, e.we);
                    chk("bank_addr", bank_addr, e.addr);
                    if (e.we) begin
                        chk("bank_wdata", bank_wdata, e.data);
                        model_mem[e.addr] = e.data;
                    end else begin
                        rd_t r;
                        r.data = model_mem[e.addr];
                        r.due  = e.due;
                        rdq.push_back(r);
                    end
                end
            end
            if (reg_spi_rd_valid) begin
                if (rdq.size() == 0) begin
                    chk("unexpected_rd_valid", reg_spi_rd_data, 32'hFFFF);
                end else begin
                    rd_t r;
                    r = rdq.pop_front();
                    chk("rd_data", reg_spi_rd_data, r.data);
                    if (r.due != 0) chk("rd_latency_cycle", cyc, r.due);
                end
                rd_log.push_back(reg_spi_rd_data);
            end else begin
                chk("rd_data_hold", reg_spi_rd_data, prev_data);
            end
            if (sample_drop) drop_cnt++;
            if (fifo_pop) pop_cnt++;
        end
        prev_data = reg_spi_rd_data;
    end

    task automatic tick();
        @(posedge mems_clk);
        #1;
    endtask

    task automatic push_acc(input bit we, input logic [6:0] a, input logic [7:0] d, input int due);
        acc_t e;
        e.we = we; e.addr = a; e.data = d; e.due = due;
        exp_q.push_back(e);
    endtask

    function automatic logic [6:0] next_addr(input logic [6:0] a);
        return (a == 7'h11) ? a : a + 7'd1;
    endfunction

    task automatic check_drained(input string name);
        chk(name, exp_q.size() + rdq.size(), 0);
    endtask

    task automatic spi_read(input logic [6:0] start, input int n);
        logic [6:0] a;
        a = start;
        cs_n = 1'b0;
        tick(); tick();
        for (int i = 0; i < n; i++) begin
            spi_wr_rd_addr = start;
            push_acc(1'b0, a, 8'h00, cyc + 3);
            spi_rd_addr_valid = 1'b1;
            repeat (4) tick();
            spi_rd_addr_valid = 1'b0;
            repeat (4) tick();
            a = next_addr(a);
        end
        tick();
        cs_n = 1'b1;
        repeat (3) tick();
        check_drained("read_burst_drained");
    endtask

    task automatic spi_write(input logic [6:0] start, input logic [23:0] bytes);
        logic [6:0] a;
        logic [7:0] b;
        a = start;
        cs_n = 1'b0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            b = bytes[23-8*i -: 8];
            spi_wr_rd_addr = start;
            spi_wr_data = b;
            push_acc(1'b1, a, b, 0);
            spi_wr_data_valid = 1'b1;
            repeat (4) tick();
            spi_wr_data_valid = 1'b0;
            repeat (4) tick();
            a = next_addr(a);
        end
        tick();
        cs_n = 1'b1;
        repeat (3) tick();
        check_drained("write_burst_drained");
    endtask

    task automatic push_sample(input logic [71:0] d);
        for (int k = 0; k < 9; k++) push_acc(1'b1, 7'h08 + 7'(k), d[71-8*k -: 8], 0);
    endtask

    task automatic send_sample(input logic [71:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        chk(name, {reg_spi_rd_valid, reg_spi_rd_data, sample_drop, fifo_pop,
                   bank_en, bank_we, bank_addr, bank_wdata}, 0);
    endtask

    initial begin
        int base;
        for (int a = 0; a < 128; a++) begin
            env_mem[a]   = 8'(a) ^ 8'hA5;
            model_mem[a] = 8'(a) ^ 8'hA5;
        end
        rst_n = 1'b0; cs_n = 1'b1;
        spi_wr_rd_addr = '0; spi_rd_addr_valid = 1'b0;
        spi_wr_data = '0; spi_wr_data_valid = 1'b0;
        sample_valid = 1'b0; sample_data = '0;
        repeat (3) @(posedge mems_clk);
        #1;
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: plain burst read from 00
        spi_read(7'h00, 3);
        chk("t1_log_size", rd_log.size(), 3);
        chk("t1_byte0", rd_log[0], 8'hA5);
        chk("t1_byte1", rd_log[1], 8'hA4);
        chk("t1_byte2", rd_log[2], 8'hA7);

        // 2: FIFO burst, address never advances
        pop_cnt = 0;
        base = rd_log.size();
        spi_read(7'h11, 4);
        chk("t2_fifo_pops", pop_cnt, 4);
        for (int i = 0; i < 4; i++) chk("t2_fifo_data", rd_log[base+i], 8'hB4);

        // 3: write burst wraps 7F -> 00
        spi_write(7'h7E, 24'h112233);
        chk("t3_mem_7E", env_mem[7'h7E], 8'h11);
        chk("t3_mem_7F", env_mem[7'h7F], 8'h22);
        chk("t3_mem_00", env_mem[7'h00], 8'h33);

        // 4: sample held while cs_n low, written on release
        drop_cnt = 0;
        cs_n = 1'b0;
        tick();
        send_sample(72'h01_02_03_04_05_06_07_08_09);
        repeat (20) tick();
        push_sample(72'h01_02_03_04_05_06_07_08_09);
        cs_n = 1'b1;
        repeat (15) tick();
        check_drained("t4_update_drained");
        for (int k = 0; k < 9; k++) chk("t4_sample_byte", env_mem[8+k], k + 1);
        chk("t4_no_drop", drop_cnt, 0);

        // 5: second sample overwrites the first
        drop_cnt = 0;
        cs_n = 1'b0;
        tick();
        send_sample(72'hAA_AA_AA_AA_AA_AA_AA_AA_AA);
        repeat (3) tick();
        send_sample(72'h11_22_33_44_55_66_77_88_99);
        repeat (5) tick();
        push_sample(72'h11_22_33_44_55_66_77_88_99);
        cs_n = 1'b1;
        repeat (15) tick();
        check_drained("t5_update_drained");
        chk("t5_drop_count", drop_cnt, 1);
        for (int k = 0; k < 9; k++) chk("t5_sample_byte", env_mem[8+k], 8'h11 * (k + 1));

        // 6: read arriving one cycle into the update waits for all 9 writes
        push_sample(72'hC0_C1_C2_C3_C4_C5_C6_C7_C8);
        send_sample(72'hC0_C1_C2_C3_C4_C5_C6_C7_C8);
        tick();
        cs_n = 1'b0;
        spi_wr_rd_addr = 7'h08;
        push_acc(1'b0, 7'h08, 8'h00, 0);
        spi_rd_addr_valid = 1'b1;
        repeat (4) tick();
        spi_rd_addr_valid = 1'b0;
        repeat (12) tick();
        cs_n = 1'b1;
        repeat (3) tick();
        check_drained("t6_drained");
        chk("t6_read_after_update", rd_log[rd_log.size()-1], 8'hC0);

        // 7: queued read discarded when cs_n rises before it is served
        base = rd_log.size();
        push_sample(72'hD0_D1_D2_D3_D4_D5_D6_D7_D8);
        send_sample(72'hD0_D1_D2_D3_D4_D5_D6_D7_D8);
        tick();
        cs_n = 1'b0;
        spi_wr_rd_addr = 7'h20;
        spi_rd_addr_valid = 1'b1;
        tick(); tick();
        cs_n = 1'b1;
        spi_rd_addr_valid = 1'b0;
        repeat (15) tick();
        check_drained("t7_drained");
        chk("t7_no_read_pulse", rd_log.size(), base);

        // 8: reset asserted while the second read of a burst is on the bank
        cs_n = 1'b0;
        tick(); tick();
        spi_wr_rd_addr = 7'h30;
        push_acc(1'b0, 7'h30, 8'h00, cyc + 3);
        spi_rd_addr_valid = 1'b1;
        repeat (4) tick();
        spi_rd_addr_valid = 1'b0;
        repeat (4) tick();
        check_drained("t8_first_byte_drained");
        spi_rd_addr_valid = 1'b1;
        @(posedge mems_clk);
        #2;
        chk("t8_mid_burst_en", bank_en, 1);
        chk("t8_mid_burst_addr", bank_addr, 7'h31);
        chk("t8_last_data", reg_spi_rd_data, 8'h95);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t8_async_reset_outputs");
        exp_q.delete();
        rdq.delete();
        spi_rd_addr_valid = 1'b0;
        cs_n = 1'b1;
        tick(); tick();
        check_outputs_zero("t8_held_reset_outputs");
        rst_n = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
